// File: rtl/conv_result_writer.sv
// conv_result_writer: write-back stage of the convolution datapath.
// Takes accumulator results over a valid/ready handshake, applies ReLU,
// requantizing right shift and saturation to DATA_W bits, and writes each
// pixel into the output feature-map RAM in raster order. Flags completion
// of one OUT_DIM x OUT_DIM map and counts pixels clipped to full scale.
module conv_result_writer #(
  parameter int OUT_DIM   = 8,
  parameter int ACC_W     = 24,
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 10,
  parameter int SHIFT     = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              res_valid,
  input  logic [ACC_W-1:0]  res_data,
  output logic              res_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              busy,
  output logic              done,
  output logic [7:0]        sat_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int CNT_W = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(OUT_DIM - 1);
  localparam bit IS_POW2 = (OUT_DIM > 1) && ((OUT_DIM & (OUT_DIM - 1)) == 0);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  logic [1:0]        state_reg, state_next;
  logic [CNT_W-1:0]  row_reg, col_reg;
  logic [7:0]        sat_reg;
  logic              ram_we_reg;
  logic [ADDR_W-1:0] ram_addr_reg;
  logic [DATA_W-1:0] ram_din_reg;
  logic [ADDR_W-1:0] cur_addr;

  logic              xfer;
  logic              start_ok;
  logic              last_pix;
  logic [ACC_W-1:0]  shifted;
  logic              is_neg;
  logic              sat_hit;
  logic [DATA_W-1:0] pix_val;

  // A new map may only begin when no map is in flight.
  assign start_ok = start && ((state_reg == S_IDLE) || (state_reg == S_DONE));
  assign xfer     = res_valid && (state_reg == S_RUN);
  assign last_pix = xfer && (row_reg == LAST_IDX) && (col_reg == LAST_IDX);

  // ReLU, then requantize; only non-negative values reach the shift so a
  // logical shift is equivalent to the arithmetic one.
  assign is_neg  = res_data[ACC_W-1];
  assign shifted = res_data >> SHIFT;
  assign sat_hit = !is_neg && (|shifted[ACC_W-1:DATA_W]);
  always_comb begin
    pix_val = shifted[DATA_W-1:0];
    if (is_neg) begin
      pix_val = '0;
    end else if (sat_hit) begin
      pix_val = '1;
    end
  end

  // Next-state logic for the map sequencer.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start_ok) state_next = S_RUN;
      S_RUN:   if (last_pix) state_next = S_FLUSH;
      S_FLUSH: state_next = S_DONE;
      S_DONE:  if (start_ok) state_next = S_RUN;
      default: state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Raster row/column counters; cleared at map start, advanced per transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_reg <= '0;
      col_reg <= '0;
    end else if (start_ok) begin
      row_reg <= '0;
      col_reg <= '0;
    end else if (xfer) begin
      if (col_reg == LAST_IDX) begin
        col_reg <= '0;
        row_reg <= (row_reg == LAST_IDX) ? '0 : row_reg + 1'b1;
      end else begin
        col_reg <= col_reg + 1'b1;
      end
    end
  end

  // Address of the pixel being accepted: a power-of-two side length lets
  // row*OUT_DIM+col collapse to concatenation, otherwise a running counter.
  generate
    if (IS_POW2) begin : gen_pow2_addr
      assign cur_addr = BASE + ADDR_W'({row_reg, col_reg});
    end else begin : gen_run_addr
      logic [ADDR_W-1:0] run_addr_reg;
      // Running address advances with every accepted pixel.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          run_addr_reg <= BASE;
        end else if (start_ok) begin
          run_addr_reg <= BASE;
        end else if (xfer) begin
          run_addr_reg <= run_addr_reg + 1'b1;
        end
      end
      assign cur_addr = run_addr_reg;
    end
  endgenerate

  // Write stage: one-cycle write pulse carrying the processed pixel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ram_we_reg   <= 1'b0;
      ram_addr_reg <= BASE;
      ram_din_reg  <= '0;
    end else begin
      ram_we_reg <= xfer;
      if (xfer) begin
        ram_addr_reg <= cur_addr;
        ram_din_reg  <= pix_val;
      end
    end
  end

  // Count of pixels clipped to full scale in this map, sticky at 255.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sat_reg <= '0;
    end else if (start_ok) begin
      sat_reg <= '0;
    end else if (xfer && sat_hit && (sat_reg != 8'hFF)) begin
      sat_reg <= sat_reg + 8'd1;
    end
  end

  assign res_ready = (state_reg == S_RUN);
  assign busy      = (state_reg == S_RUN) || (state_reg == S_FLUSH);
  assign done      = (state_reg == S_DONE);
  assign ram_we    = ram_we_reg;
  assign ram_addr  = ram_addr_reg;
  assign ram_din   = ram_din_reg;
  assign sat_count = sat_reg;

endmodule

// File: tb/tb_conv_result_writer.sv
// Testbench for conv_result_writer: table-driven pixel vectors plus a
// write scoreboard, map sequencing, mid-map start/reset and a second
// instance with a non power-of-two side for sticky saturation.
module tb_conv_result_writer;

  localparam int NPIX = 64;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, res_valid;
  logic [23:0] res_data;
  logic        res_ready, ram_we, busy, done;
  logic [9:0]  ram_addr;
  logic [7:0]  ram_din, sat_count;

  logic        b_start, b_valid;
  logic [23:0] b_data;
  logic        b_ready, b_we, b_busy, b_done;
  logic [9:0]  b_addr;
  logic [7:0]  b_din, b_sat;

  conv_result_writer dut (
    .clk(clk), .reset(reset), .start(start), .res_valid(res_valid),
    .res_data(res_data), .res_ready(res_ready), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_din(ram_din), .busy(busy), .done(done),
    .sat_count(sat_count)
  );

  conv_result_writer #(.OUT_DIM(20)) u_big (
    .clk(clk), .reset(reset), .start(b_start), .res_valid(b_valid),
    .res_data(b_data), .res_ready(b_ready), .ram_we(b_we),
    .ram_addr(b_addr), .ram_din(b_din), .busy(b_busy), .done(b_done),
    .sat_count(b_sat)
  );

  typedef struct { logic [23:0] data; logic [7:0] exp; bit sat; } vec_t;
  typedef struct { logic [9:0] addr; logic [7:0] din; } wr_t;

  vec_t vecs[10];
  wr_t  sb[$];
  int   errors = 0, checks = 0;
  int   wr_count = 0, pix_idx = 0, exp_sat = 0;
  int   b_wr_count = 0, b_exp_addr = 0;
  logic [7:0] mem [0:NPIX-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_pix(input logic [23:0] d);
    int v;
    v = $signed(d);
    if (v < 0) return 8'd0;
    if (v / 256 > 255) return 8'd255;
    return 8'(v / 256);
  endfunction

  function automatic bit ref_sat(input logic [23:0] d);
    int v;
    v = $signed(d);
    return (v >= 0) && (v / 256 > 255);
  endfunction

  function automatic logic [23:0] rand_data();
    logic [23:0] r;
    case ($urandom_range(0, 3))
      0: r = 24'h800000 | 24'($urandom_range(0, 24'h7FFFFF));
      1: r = 24'($urandom_range(0, 16'hFFFF));
      2: r = 24'($urandom_range(0, 24'h7FFFFF));
      default: r = 24'($urandom_range(0, 16'h4FFF));
    endcase
    return r;
  endfunction

  // Scoreboard for the main instance: every write must match the oldest
  // expected transfer, and every expected transfer must produce a write.
  always @(negedge clk) begin
    wr_t e;
    if (ram_we === 1'b1) begin
      wr_count++;
      if (sb.size() == 0) begin
        chk("unexpected_write", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", 32'(ram_addr), 32'(e.addr));
        chk("wr_din", 32'(ram_din), 32'(e.din));
        mem[ram_addr[5:0]] = ram_din;
      end
    end else if (sb.size() != 0) begin
      sb.delete();
      chk("missing_write", 0, 1);
    end
  end

  // Big instance: addresses must be strictly sequential from 0.
  always @(negedge clk) begin
    if (b_we === 1'b1) begin
      chk("big_addr", 32'(b_addr), 32'(b_exp_addr));
      chk("big_din", 32'(b_din), 255);
      b_exp_addr++;
      b_wr_count++;
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "_ready"}, res_ready, 0);
    chk({tag, "_we"}, ram_we, 0);
    chk({tag, "_addr"}, 32'(ram_addr), 0);
    chk({tag, "_din"}, 32'(ram_din), 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_sat"}, 32'(sat_count), 0);
  endtask

  // Called at posedge+1; returns at posedge+1 after the pixel is accepted.
  task automatic drive_pixel(input logic [23:0] d, input logic [7:0] exp_din);
    wr_t e;
    res_valid = 1'b1;
    res_data  = d;
    @(negedge clk);
    chk("res_ready", res_ready, 1);
    @(posedge clk);
    #1;
    e.addr = 10'(pix_idx);
    e.din  = exp_din;
    sb.push_back(e);
    pix_idx++;
  endtask

  task automatic idle(input int n);
    res_valid = 1'b0;
    res_data  = 24'hDEAD00;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    pix_idx  = 0;
    wr_count = 0;
    exp_sat  = 0;
  endtask

  task automatic random_pixel(input bit bubbly);
    logic [23:0] d;
    if (bubbly && $urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    d = rand_data();
    drive_pixel(d, ref_pix(d));
    if (ref_sat(d) && exp_sat < 255) exp_sat++;
  endtask

  task automatic finish_map(input string tag);
    res_valid = 1'b0;
    idle(1);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_writes"}, 32'(wr_count), NPIX);
    chk({tag, "_sat"}, 32'(sat_count), 32'(exp_sat));
  endtask

  initial begin
    int bad;
    vecs[0] = '{24'h000100, 8'h01, 1'b0};
    vecs[1] = '{24'h00FF00, 8'hFF, 1'b0};
    vecs[2] = '{24'h00FFFF, 8'hFF, 1'b0};
    vecs[3] = '{24'h010000, 8'hFF, 1'b1};
    vecs[4] = '{24'h7FFFFF, 8'hFF, 1'b1};
    vecs[5] = '{24'hFFFFFF, 8'h00, 1'b0};
    vecs[6] = '{24'h800000, 8'h00, 1'b0};
    vecs[7] = '{24'h0000FF, 8'h00, 1'b0};
    vecs[8] = '{24'h001234, 8'h12, 1'b0};
    vecs[9] = '{24'h00AB00, 8'hAB, 1'b0};

    reset = 1'b1; start = 1'b0; res_valid = 1'b0; res_data = '0;
    b_start = 1'b0; b_valid = 1'b0; b_data = '0;
    #2 reset = 1'b0;
    @(negedge clk);
    check_reset("rst");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    idle(1);

    // Map 1: back-to-back ramp, pixel i lands at address i.
    pulse_start();
    chk("m1_busy", busy, 1);
    chk("m1_ready", res_ready, 1);
    chk("m1_done0", done, 0);
    for (int i = 0; i < NPIX; i++) drive_pixel(24'(i << 8), 8'(i));
    chk("m1_flush_ready", res_ready, 0);
    chk("m1_flush_busy", busy, 1);
    chk("m1_flush_done", done, 0);
    idle(1);
    chk("m1_done", done, 1);
    chk("m1_busy_end", busy, 0);
    chk("m1_sat", 32'(sat_count), 0);
    chk("m1_writes", 32'(wr_count), NPIX);
    bad = 0;
    for (int i = 0; i < NPIX; i++) if (mem[i] !== 8'(i)) bad++;
    chk("m1_mem_bad", 32'(bad), 0);
    // valid held high in DONE must not cause writes; done stays up
    res_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("m1_done_hold", done, 1);
    res_valid = 1'b0;

    // Map 2: table vectors, then bubbly random traffic.
    pulse_start();
    chk("m2_done_drop", done, 0);
    chk("m2_busy", busy, 1);
    for (int i = 0; i < 10; i++) begin
      drive_pixel(vecs[i].data, vecs[i].exp);
      if (vecs[i].sat) exp_sat++;
    end
    chk("m2_sat_table", 32'(sat_count), 2);
    for (int i = 10; i < NPIX; i++) random_pixel(1'b1);
    finish_map("m2");

    // Map 3: start during pixel 20 is ignored.
    pulse_start();
    chk("m3_sat_clr", 32'(sat_count), 0);
    for (int i = 0; i < NPIX; i++) begin
      start = (i == 20);
      random_pixel(1'b0);
    end
    start = 1'b0;
    finish_map("m3");

    // Map 4: asynchronous reset at pixel 30, then a full bubbly map.
    pulse_start();
    for (int i = 0; i < 30; i++) random_pixel(1'b0);
    res_valid = 1'b0;
    #2 reset = 1'b0;
    sb.delete();
    #1;
    check_reset("async_rst");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    idle(2);
    chk("post_rst_busy", busy, 0);
    pulse_start();
    for (int i = 0; i < NPIX; i++) random_pixel(1'b1);
    finish_map("m4");

    // 20x20 map, every pixel clipped: sat_count must stick at 255.
    b_start = 1'b1;
    @(posedge clk);
    #1 b_start = 1'b0;
    b_valid = 1'b1;
    b_data  = 24'h7FFFFF;
    repeat (400) @(posedge clk);
    #1 b_valid = 1'b0;
    chk("big_flush_ready", b_ready, 0);
    @(posedge clk);
    #1;
    chk("big_done", b_done, 1);
    chk("big_sat_hold", 32'(b_sat), 255);
    @(negedge clk);
    chk("big_writes", 32'(b_wr_count), 400);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_result_writer.md
# conv_result_writer

Write-back stage of the convolution datapath: accepts requantized-to-be convolution results from the `conv` engine over a valid/ready handshake, applies ReLU, scaling and saturation, and writes each 8-bit pixel into an output feature-map block RAM in raster order. It is the writer at the far end of the image/kernel read path: the top-level loader reads the ImageRAM and KernelRAM, and this block fills the result RAM and flags completion of one output map.

## Interface
- `OUT_DIM`, 8: output map side length (28 − 21 + 1); map holds `OUT_DIM*OUT_DIM` pixels.
- `ACC_W`, 24: width of the convolution accumulator result.
- `DATA_W`, 8: width of a stored output pixel.
- `ADDR_W`, 10: result RAM address width.
- `SHIFT`, 8: arithmetic right shift applied after ReLU (requantization).
- `BASE_ADDR`, 0: RAM address of pixel (0,0).

- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  reset, asynchronous, active-low.
- `start`  in  1  single-cycle pulse; begins a new output map.
- `res_valid`  in  1  `res_data` holds a valid result.
- `res_data`  in  ACC_W  convolution result, two's complement.
- `res_ready`  out  1  block accepts `res_data` this cycle.
- `ram_we`  out  1  result RAM write enable (port A).
- `ram_addr`  out  ADDR_W  result RAM address.
- `ram_din`  out  DATA_W  result RAM write data.
- `busy`  out  1  map in progress (RUN or FLUSH).
- `done`  out  1  map fully written; held until next `start`.
- `sat_count`  out  8  number of pixels clipped to max in current map; saturates at 255.

## Operation
- States: IDLE, RUN, FLUSH, DONE.
- IDLE: `res_ready`=0. `start` → RUN; clears pixel counter, row/col counters, `sat_count`, `done`.
- RUN: `res_ready`=1. Transfer occurs when `res_valid & res_ready`. On each transfer, register the processed pixel and its address into the write stage; increment col; col wrap at `OUT_DIM-1` → col=0, row+1.
- On the transfer of pixel `OUT_DIM*OUT_DIM-1` (row=col=OUT_DIM-1): → FLUSH.
- FLUSH: `res_ready`=0; final write issues; → DONE next cycle.
- DONE: `done`=1, `busy`=0, `res_ready`=0. `start` → RUN (new map, counters cleared, `done` drops).
- `start` while RUN/FLUSH: ignored. `start` simultaneous with a transfer is impossible (ready=0 in IDLE/DONE).
- Pixel processing: v = res_data signed; if v<0 → 0 (ReLU); else s = v >>> SHIFT; if s > 2^DATA_W−1 → 2^DATA_W−1 and `sat_count`+1 (hold at 255); else s[DATA_W-1:0].
- Address: `ram_addr` = BASE_ADDR + row*OUT_DIM + col, computed from counters (no multiplier needed when OUT_DIM is a power of two; otherwise a running address counter); wraps modulo 2^ADDR_W.
- `res_valid` low in RUN: no transfer, counters hold, `ram_we`=0 next cycle.

## Timing
- Reset (async assert, sync deassert assumed at top): state=IDLE, `res_ready`=0, `ram_we`=0, `ram_addr`=BASE_ADDR, `ram_din`=0, `busy`=0, `done`=0, `sat_count`=0, counters 0.
- `start` at edge N → RUN at N+1; `res_ready`=1, `busy`=1 from N+1.
- Latency: transfer at edge T → `ram_we`=1 with its `ram_addr`/`ram_din` during cycle T..T+1 (registered outputs, written by RAM at edge T+1). One pixel per cycle sustained.
- `ram_we` is a one-cycle pulse per transfer; never asserted outside a transfer+1 slot.
- Last transfer at edge L: `res_ready`=0 from L; last `ram_we` during L..L+1; `done`=1 and `busy`=0 from edge L+1.
- Reset mid-map: all outputs to reset values immediately; partial RAM contents undefined to consumers; a new `start` is required.
- `res_data` must be stable only in transfer cycles; ignored otherwise.

## Test plan
- Reset then `start`, 64 back-to-back transfers with res_data = i<<8 (i=0..63) -> RAM addr i holds i, 64 `ram_we` pulses, `done`=1 one cycle after 64th transfer, `sat_count`=0.
- Negative inputs: res_data = −1, −0x800000 -> ram_din=0, no `sat_count` increment.
- Saturation: res_data = 0x7FFFFF and 0x010000 -> ram_din=255 each, `sat_count`=2; 300 clipped pixels across map -> `sat_count` holds 255.
- Bubbly `res_valid` (random 50%) -> same RAM contents as back-to-back, addresses strictly 0..63 in order, no write on idle cycles.
- `start` asserted mid-map (pixel 20) -> ignored, map completes normally; `start` in DONE -> `done` drops, new map writes from addr BASE_ADDR.
- Async reset low at pixel 30 -> outputs at reset values without clock edge; after release and `start`, full map written correctly.
